// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared states, coin values and key indices for the vending controller
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_e;

    localparam int COIN_HALF = 1;
    localparam int COIN_ONE  = 2;

    localparam int KEY_CANCEL = 0;
    localparam int KEY_HALF   = 1;
    localparam int KEY_ONE    = 2;

endpackage

// File: rtl/key_sync_edge.sv
// rtl/key_sync_edge.sv - per-bit 2-FF synchroniser with falling-edge pulse for active-low keys
module key_sync_edge #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_n,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Reset to the released level so leaving reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign fall = prev_q & ~sync2_q;

endmodule

// File: rtl/vending_machine_param.sv
// rtl/vending_machine_param.sv - parametrised vending controller with handshaked change return
module vending_machine_param #(
    parameter int PRICE       = 5,
    parameter int CREDIT_W    = 4,
    parameter int BEEP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          key_value,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] money_flag,
    output logic                vend,
    output logic                beep,
    output logic                coin_reject,
    output logic                change_valid,
    output logic                change_coin
);
    import vending_pkg::*;

    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);
    localparam logic [CREDIT_W:0]   CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_X    = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] TWO        = CREDIT_W'(COIN_ONE);

    logic [2:0] ev;

    key_sync_edge #(.WIDTH(3)) u_keys (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_value),
        .fall  (ev)
    );

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic                vend_q, vend_d;
    logic                reject_q, reject_d;
    logic                change_valid_q, change_valid_d;
    logic                change_coin_q, change_coin_d;

    logic                cancel_ev, one_ev, half_ev, coin_ev, dropped;
    logic [CREDIT_W:0]   coin_val, sum;
    logic [CREDIT_W-1:0] rem;

    always_comb begin
        cancel_ev = ev[KEY_CANCEL];
        one_ev    = ev[KEY_ONE];
        half_ev   = ev[KEY_HALF];
        coin_ev   = !cancel_ev && (one_ev || half_ev);
        coin_val  = one_ev ? (CREDIT_W+1)'(COIN_ONE) : (CREDIT_W+1)'(COIN_HALF);
        // Coins losing same-cycle priority collapse into one reject pulse.
        dropped   = cancel_ev ? (one_ev || half_ev) : (one_ev && half_ev);
        sum       = {1'b0, credit_q} + coin_val;
        rem       = credit_q;

        state_d        = state_q;
        credit_d       = credit_q;
        vend_d         = 1'b0;
        reject_d       = dropped;
        change_valid_d = change_valid_q;
        change_coin_d  = change_coin_q;
        beep_cnt_d     = (beep_cnt_q != '0) ? beep_cnt_q - 1'b1 : '0;

        case (state_q)
            IDLE, COLLECT: begin
                if (cancel_ev) begin
                    if (state_q == COLLECT) begin
                        state_d        = CHANGE;
                        change_valid_d = 1'b1;
                        change_coin_d  = (credit_q >= TWO);
                    end
                end else if (coin_ev) begin
                    if (sum > CREDIT_MAX) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                        if (sum >= PRICE_X) begin
                            state_d    = VEND;
                            vend_d     = 1'b1;
                            beep_cnt_d = BEEP_W'(BEEP_CYCLES);
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end
            end
            VEND: begin
                reject_d = one_ev || half_ev;
                rem      = credit_q - PRICE_C;
                credit_d = rem;
                if (rem != '0) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_coin_d  = (rem >= TWO);
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                reject_d = one_ev || half_ev;
                if (change_valid_q && change_ready) begin
                    rem      = credit_q - (change_coin_q ? TWO : CREDIT_W'(COIN_HALF));
                    credit_d = rem;
                    if (rem == '0) begin
                        state_d        = IDLE;
                        change_valid_d = 1'b0;
                        change_coin_d  = 1'b0;
                    end else begin
                        change_coin_d  = (rem >= TWO);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            beep_cnt_q     <= '0;
            vend_q         <= 1'b0;
            reject_q       <= 1'b0;
            change_valid_q <= 1'b0;
            change_coin_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            beep_cnt_q     <= beep_cnt_d;
            vend_q         <= vend_d;
            reject_q       <= reject_d;
            change_valid_q <= change_valid_d;
            change_coin_q  <= change_coin_d;
        end
    end

    assign money_flag   = credit_q;
    assign vend         = vend_q;
    assign beep         = (beep_cnt_q != '0);
    assign coin_reject  = reject_q;
    assign change_valid = change_valid_q;
    assign change_coin  = change_coin_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// tb/tb_vending_machine_param.sv - table-driven scoreboard bench for vending_machine_param
module tb_vending_machine_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] key_value;
    logic       change_ready;
    logic [3:0] money_flag;
    logic       vend, beep, coin_reject, change_valid, change_coin;

    logic [2:0] key15;
    logic       ready15;
    logic [3:0] money15;
    logic       vend15, beep15, rej15, cv15, cc15;

    always #5 clk = ~clk;

    vending_machine_param dut (
        .clk(clk), .rst_n(rst_n), .key_value(key_value), .change_ready(change_ready),
        .money_flag(money_flag), .vend(vend), .beep(beep), .coin_reject(coin_reject),
        .change_valid(change_valid), .change_coin(change_coin)
    );

    vending_machine_param #(.PRICE(15), .CREDIT_W(4), .BEEP_CYCLES(4)) dut15 (
        .clk(clk), .rst_n(rst_n), .key_value(key15), .change_ready(ready15),
        .money_flag(money15), .vend(vend15), .beep(beep15), .coin_reject(rej15),
        .change_valid(cv15), .change_coin(cc15)
    );

    typedef struct {
        int         idx;
        logic [2:0] key;
        logic       ready;
        logic [3:0] money;
        logic       vend, beep, rej, cv, cc;
    } vec_t;

    localparam logic [2:0] KN  = 3'b111;
    localparam logic [2:0] KH  = 3'b101;
    localparam logic [2:0] KO  = 3'b011;
    localparam logic [2:0] KC  = 3'b110;
    localparam logic [2:0] KCH = 3'b100;

    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, want);
        end
    endtask

    task automatic add(input logic [2:0] k, input logic r, input logic [3:0] m,
                       input logic v, input logic b, input logic rj, input logic cv, input logic cc);
        vec_t t;
        t.idx = vecs.size(); t.key = k; t.ready = r; t.money = m;
        t.vend = v; t.beep = b; t.rej = rj; t.cv = cv; t.cc = cc;
        vecs.push_back(t);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("money_flag",   e.idx, {4'd0, money_flag}, {4'd0, e.money});
            chk("vend",         e.idx, {7'd0, vend},         {7'd0, e.vend});
            chk("beep",         e.idx, {7'd0, beep},         {7'd0, e.beep});
            chk("coin_reject",  e.idx, {7'd0, coin_reject},  {7'd0, e.rej});
            chk("change_valid", e.idx, {7'd0, change_valid}, {7'd0, e.cv});
            chk("change_coin",  e.idx, {7'd0, change_coin},  {7'd0, e.cc});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic press15(input logic [2:0] k);
        @(negedge clk); key15 = k;
        @(negedge clk); key15 = KN;
    endtask

    task automatic press(input logic [2:0] k);
        @(negedge clk); key_value = k;
        @(negedge clk); key_value = KN;
    endtask

    initial begin
        rst_n = 1'b0; key_value = KN; change_ready = 1'b0; key15 = KN; ready15 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_money", -1, {4'd0, money_flag}, 8'd0);
        chk("rst_outs", -1, {3'd0, vend, beep, coin_reject, change_valid, change_coin}, 8'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 10; i++) add(KN, 0, 0, 0, 0, 0, 0, 0);
        // exact price: 0.5, 1.0, 1.0
        add(KH, 0, 0, 0, 0, 0, 0, 0);  add(KN, 0, 0, 0, 0, 0, 0, 0);
        add(KO, 0, 1, 0, 0, 0, 0, 0);  add(KN, 0, 1, 0, 0, 0, 0, 0);
        add(KO, 0, 3, 0, 0, 0, 0, 0);  add(KN, 0, 3, 0, 0, 0, 0, 0);
        add(KN, 0, 5, 1, 1, 0, 0, 0);  add(KN, 0, 0, 0, 1, 0, 0, 0);
        add(KN, 0, 0, 0, 1, 0, 0, 0);  add(KN, 0, 0, 0, 1, 0, 0, 0);
        add(KN, 0, 0, 0, 0, 0, 0, 0);
        // overpay: 1.0 x3, one half coin back
        add(KO, 0, 0, 0, 0, 0, 0, 0);  add(KN, 0, 0, 0, 0, 0, 0, 0);
        add(KO, 0, 2, 0, 0, 0, 0, 0);  add(KN, 0, 2, 0, 0, 0, 0, 0);
        add(KO, 0, 4, 0, 0, 0, 0, 0);  add(KN, 0, 4, 0, 0, 0, 0, 0);
        add(KN, 0, 6, 1, 1, 0, 0, 0);  add(KN, 0, 1, 0, 1, 0, 1, 0);
        add(KN, 1, 0, 0, 1, 0, 0, 0);  add(KN, 0, 0, 0, 1, 0, 0, 0);
        add(KN, 0, 0, 0, 0, 0, 0, 0);
        // refund of 3 with backpressure
        add(KH, 0, 0, 0, 0, 0, 0, 0);  add(KN, 0, 0, 0, 0, 0, 0, 0);
        add(KO, 0, 1, 0, 0, 0, 0, 0);  add(KN, 0, 1, 0, 0, 0, 0, 0);
        add(KC, 0, 3, 0, 0, 0, 0, 0);  add(KN, 0, 3, 0, 0, 0, 0, 0);
        add(KN, 0, 3, 0, 0, 0, 1, 1);  add(KN, 0, 3, 0, 0, 0, 1, 1);
        add(KN, 0, 3, 0, 0, 0, 1, 1);  add(KN, 0, 3, 0, 0, 0, 1, 1);
        add(KN, 1, 1, 0, 0, 0, 1, 0);  add(KN, 1, 0, 0, 0, 0, 0, 0);
        add(KN, 0, 0, 0, 0, 0, 0, 0);
        // cancel + 0.5 together, then a coin while locked in CHANGE
        add(KO,  0, 0, 0, 0, 0, 0, 0); add(KN, 0, 0, 0, 0, 0, 0, 0);
        add(KCH, 0, 2, 0, 0, 0, 0, 0); add(KN, 0, 2, 0, 0, 0, 0, 0);
        add(KN,  0, 2, 0, 0, 1, 1, 1); add(KH, 0, 2, 0, 0, 0, 1, 1);
        add(KN,  0, 2, 0, 0, 0, 1, 1); add(KN, 0, 2, 0, 0, 1, 1, 1);
        add(KN,  1, 0, 0, 0, 0, 0, 0); add(KN, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            key_value    = vecs[i].key;
            change_ready = vecs[i].ready;
            exp_q.push_back(vecs[i]);
        end
        for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
            exp_q.delete();
        end

        // saturation with PRICE=15: credit 14, a further 1.0 is rejected
        for (int i = 0; i < 7; i++) press15(KO);
        @(posedge clk); @(posedge clk); #1;
        chk("sat_credit14", 0, {4'd0, money15}, 8'd14);
        chk("sat_noreject", 0, {7'd0, rej15}, 8'd0);
        press15(KO);
        @(posedge clk); @(posedge clk); #1;
        chk("sat_reject", 0, {7'd0, rej15}, 8'd1);
        chk("sat_hold14", 0, {4'd0, money15}, 8'd14);
        @(posedge clk); #1;
        chk("sat_pulse_end", 0, {7'd0, rej15}, 8'd0);
        chk("sat_no_vend", 0, {6'd0, vend15, cv15}, 8'd0);

        // reset asserted while change is pending
        change_ready = 1'b0;
        for (int i = 0; i < 3; i++) press(KO);
        repeat (4) @(posedge clk); #1;
        chk("pre_rst_valid", 0, {7'd0, change_valid}, 8'd1);
        chk("pre_rst_money", 0, {4'd0, money_flag}, 8'd1);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst_mid_valid", 0, {7'd0, change_valid}, 8'd0);
        chk("rst_mid_money", 0, {4'd0, money_flag}, 8'd0);
        chk("rst_mid_beep", 0, {7'd0, beep}, 8'd0);
        @(negedge clk); rst_n = 1'b1; change_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("post_rst_outs", 0, {money_flag, vend, beep, coin_reject, change_valid}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
